// File: rtl/psum_gbf_packer_if.sv
// psum_gbf_packer_if: read/write port bundle between the packer and the psum global buffer
interface psum_gbf_packer_if #(
    parameter int GBF_DATA_BITWIDTH = 512,
    parameter int GBF_ADDR_BITWIDTH = 8
);
    logic [GBF_DATA_BITWIDTH-1:0] out_data;
    logic                         psum_gbf_w_en;
    logic [GBF_ADDR_BITWIDTH-1:0] psum_gbf_w_addr;
    logic                         psum_gbf_r_en;
    logic [GBF_ADDR_BITWIDTH-1:0] psum_gbf_r_addr;
    logic                         psum_gbf_w_num;
    logic [GBF_DATA_BITWIDTH-1:0] psum_gbf_r_data;

    modport master (
        output out_data, psum_gbf_w_en, psum_gbf_w_addr, psum_gbf_r_en, psum_gbf_r_addr, psum_gbf_w_num,
        input  psum_gbf_r_data
    );

    modport slave (
        input  out_data, psum_gbf_w_en, psum_gbf_w_addr, psum_gbf_r_en, psum_gbf_r_addr, psum_gbf_w_num,
        output psum_gbf_r_data
    );
endinterface

// File: rtl/psum_gbf_packer.sv
// psum_gbf_packer: serialises a PE-array psum snapshot into gbf beats, optionally accumulating into the gbf
module psum_gbf_packer #(
    parameter int ROW                   = 16,
    parameter int COL                   = 16,
    parameter int DATA_BITWIDTH         = 16,
    parameter int GBF_DATA_BITWIDTH     = 512,
    parameter int PSUM_RF_ADDR_BITWIDTH = 2,
    parameter int GBF_ADDR_BITWIDTH     = 8
) (
    input  logic                                 clk,
    input  logic                                 reset_n,
    input  logic [DATA_BITWIDTH*ROW*COL-1:0]     psum_out,
    input  logic                                 pe_psum_finish,
    input  logic                                 conv_finish,
    input  logic [7:0]                           cfg_rel_num,
    input  logic [7:0]                           cfg_irrel_num,
    input  logic                                 cfg_acc_en,
    output logic [PSUM_RF_ADDR_BITWIDTH-1:0]     psum_rf_addr,
    output logic                                 su_add_finish,
    output logic                                 overrun,
    output logic                                 done,
    psum_gbf_packer_if.master                    gbf
);
    localparam int W     = DATA_BITWIDTH * ROW * COL;
    localparam int G     = GBF_DATA_BITWIDTH;
    localparam int BEATS = W / G;
    localparam int LANES = G / DATA_BITWIDTH;
    localparam int BW    = $clog2(BEATS + 1);
    localparam int AW    = GBF_ADDR_BITWIDTH;

    typedef enum logic [1:0] {IDLE, SEND, FLUSH, FINISH} state_t;

    state_t                           state_q, state_d;
    logic [W-1:0]                     snap_q, snap_d;
    logic [BW-1:0]                    beat_q, beat_d;
    logic [7:0]                       rel_idx_q, rel_idx_d, irrel_idx_q, irrel_idx_d;
    logic [7:0]                       rel_num_q, rel_num_d, irrel_num_q, irrel_num_d;
    logic                             acc_q, acc_d, conv_pend_q, conv_pend_d;
    logic [PSUM_RF_ADDR_BITWIDTH-1:0] rf_addr_q, rf_addr_d;
    logic                             w_num_q, w_num_d, overrun_q, overrun_d;
    logic                             su_q, su_d, done_q, done_d;
    logic                             w_en_q, w_en_d, r_en_q, r_en_d, wacc_q, wacc_d;
    logic [AW-1:0]                    w_addr_q, w_addr_d, r_addr_q, r_addr_d;
    logic [G-1:0]                     wdata_q, wdata_d, rbeat_q, rbeat_d;
    logic [G-1:0]                     acc_sum;
    logic [AW-1:0]                    beat_addr;
    logic                             burst_end, rel_wrap, irrel_wrap;
    logic [7:0]                       rel_inc, irrel_inc;

    assign beat_addr  = AW'(32'(rel_idx_q) * 32'(BEATS) + 32'(beat_q));
    assign rel_inc    = rel_idx_q + 8'd1;
    assign irrel_inc  = irrel_idx_q + 8'd1;
    assign rel_wrap   = rel_inc >= rel_num_q;
    assign irrel_wrap = rel_wrap && irrel_inc >= irrel_num_q;

    // Lane-wise modular add of gbf read data and the held beat; carries never cross lanes
    always_comb begin
        acc_sum = '0;
        for (int i = 0; i < LANES; i++)
            acc_sum[i*DATA_BITWIDTH +: DATA_BITWIDTH] = gbf.psum_gbf_r_data[i*DATA_BITWIDTH +: DATA_BITWIDTH]
                                                      + wdata_q[i*DATA_BITWIDTH +: DATA_BITWIDTH];
    end

    // Next-state, beat issue and tile-counter update logic
    always_comb begin
        state_d     = state_q;
        snap_d      = snap_q;
        beat_d      = beat_q;
        rel_idx_d   = rel_idx_q;
        irrel_idx_d = irrel_idx_q;
        rel_num_d   = rel_num_q;
        irrel_num_d = irrel_num_q;
        acc_d       = acc_q;
        conv_pend_d = conv_pend_q;
        rf_addr_d   = rf_addr_q;
        w_num_d     = w_num_q;
        overrun_d   = overrun_q | (pe_psum_finish && state_q != IDLE);
        w_en_d      = 1'b0;
        w_addr_d    = w_addr_q;
        wdata_d     = wdata_q;
        wacc_d      = 1'b0;
        r_en_d      = 1'b0;
        r_addr_d    = r_addr_q;
        rbeat_d     = rbeat_q;
        burst_end   = 1'b0;
        // a read issued last cycle turns into the accumulate write to the same address now
        if (r_en_q) begin
            w_en_d   = 1'b1;
            w_addr_d = r_addr_q;
            wdata_d  = rbeat_q;
            wacc_d   = 1'b1;
        end
        case (state_q)
            IDLE: begin
                if (pe_psum_finish) begin
                    snap_d      = psum_out;
                    beat_d      = '0;
                    rel_num_d   = cfg_rel_num == 8'd0 ? 8'd1 : cfg_rel_num;
                    irrel_num_d = cfg_irrel_num == 8'd0 ? 8'd1 : cfg_irrel_num;
                    acc_d       = cfg_acc_en && irrel_idx_q != 8'd0;
                    conv_pend_d = conv_finish;
                    state_d     = SEND;
                end else if (conv_finish) begin
                    state_d = FINISH;
                end
            end
            SEND: begin
                conv_pend_d = conv_pend_q | conv_finish;
                if (beat_q == BW'(BEATS)) begin
                    if (acc_q) state_d = FLUSH;
                    else burst_end = 1'b1;
                end else begin
                    beat_d = beat_q + BW'(1);
                    snap_d = snap_q << G;
                    if (acc_q) begin
                        r_en_d   = 1'b1;
                        r_addr_d = beat_addr;
                        rbeat_d  = snap_q[W-1 -: G];
                    end else begin
                        w_en_d   = 1'b1;
                        w_addr_d = beat_addr;
                        wdata_d  = snap_q[W-1 -: G];
                    end
                end
            end
            FLUSH: begin
                conv_pend_d = conv_pend_q | conv_finish;
                burst_end   = 1'b1;
            end
            default: ;
        endcase
        if (burst_end) begin
            rf_addr_d   = rf_addr_q + 1'b1;
            rel_idx_d   = rel_wrap ? 8'd0 : rel_inc;
            irrel_idx_d = rel_wrap ? (irrel_wrap ? 8'd0 : irrel_inc) : irrel_idx_q;
            w_num_d     = w_num_q ^ irrel_wrap;
            state_d     = (conv_pend_q || conv_finish) ? FINISH : IDLE;
            conv_pend_d = 1'b0;
        end
        su_d   = state_d == IDLE;
        done_d = state_d == FINISH;
    end

    // State and output registers; reset aborts any burst immediately
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            snap_q      <= '0;
            beat_q      <= '0;
            rel_idx_q   <= '0;
            irrel_idx_q <= '0;
            rel_num_q   <= 8'd1;
            irrel_num_q <= 8'd1;
            acc_q       <= 1'b0;
            conv_pend_q <= 1'b0;
            rf_addr_q   <= '0;
            w_num_q     <= 1'b0;
            overrun_q   <= 1'b0;
            su_q        <= 1'b1;
            done_q      <= 1'b0;
            w_en_q      <= 1'b0;
            w_addr_q    <= '0;
            wdata_q     <= '0;
            wacc_q      <= 1'b0;
            r_en_q      <= 1'b0;
            r_addr_q    <= '0;
            rbeat_q     <= '0;
        end else begin
            state_q     <= state_d;
            snap_q      <= snap_d;
            beat_q      <= beat_d;
            rel_idx_q   <= rel_idx_d;
            irrel_idx_q <= irrel_idx_d;
            rel_num_q   <= rel_num_d;
            irrel_num_q <= irrel_num_d;
            acc_q       <= acc_d;
            conv_pend_q <= conv_pend_d;
            rf_addr_q   <= rf_addr_d;
            w_num_q     <= w_num_d;
            overrun_q   <= overrun_d;
            su_q        <= su_d;
            done_q      <= done_d;
            w_en_q      <= w_en_d;
            w_addr_q    <= w_addr_d;
            wdata_q     <= wdata_d;
            wacc_q      <= wacc_d;
            r_en_q      <= r_en_d;
            r_addr_q    <= r_addr_d;
            rbeat_q     <= rbeat_d;
        end
    end

    assign psum_rf_addr        = rf_addr_q;
    assign su_add_finish       = su_q;
    assign overrun             = overrun_q;
    assign done                = done_q;
    assign gbf.psum_gbf_w_en   = w_en_q;
    assign gbf.psum_gbf_w_addr = w_addr_q;
    assign gbf.psum_gbf_r_en   = r_en_q;
    assign gbf.psum_gbf_r_addr = r_addr_q;
    assign gbf.psum_gbf_w_num  = w_num_q;
    // accumulate writes combine the registered beat with read data arriving this cycle
    assign gbf.out_data        = wacc_q ? acc_sum : wdata_q;
endmodule

// File: tb/tb_psum_gbf_packer.sv
// tb_psum_gbf_packer: directed checks of beat order, addressing, accumulation, overrun, finish and reset
module tb_psum_gbf_packer;
    localparam int D = 16, W = 4096, G = 512, BEATS = 8, A = 8;

    logic           clk = 1'b0, reset_n = 1'b0;
    logic [W-1:0]   psum_out = '0;
    logic           pe_psum_finish = 1'b0, conv_finish = 1'b0, cfg_acc_en = 1'b0;
    logic [7:0]     cfg_rel_num = 8'd4, cfg_irrel_num = 8'd1;
    logic [1:0]     psum_rf_addr;
    logic           su_add_finish, overrun, done;
    logic           clr_mem = 1'b1;
    logic [G-1:0]   mem [256];
    int             cyc = 0, c0 = 0, tests = 0, fails = 0, sc = 0;
    logic [A-1:0]   wq_addr[$], rq_addr[$];
    logic [G-1:0]   wq_data[$];
    int             wq_cyc[$];

    psum_gbf_packer_if #(.GBF_DATA_BITWIDTH(G), .GBF_ADDR_BITWIDTH(A)) bus ();

    psum_gbf_packer dut (
        .clk(clk), .reset_n(reset_n), .psum_out(psum_out),
        .pe_psum_finish(pe_psum_finish), .conv_finish(conv_finish),
        .cfg_rel_num(cfg_rel_num), .cfg_irrel_num(cfg_irrel_num), .cfg_acc_en(cfg_acc_en),
        .psum_rf_addr(psum_rf_addr), .su_add_finish(su_add_finish),
        .overrun(overrun), .done(done), .gbf(bus)
    );

    always #5 clk = ~clk;

    // Synchronous gbf model: read data valid the cycle after r_en
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (clr_mem) begin
            for (int i = 0; i < 256; i++) mem[i] <= '0;
            bus.psum_gbf_r_data <= '0;
        end else begin
            if (bus.psum_gbf_w_en) mem[bus.psum_gbf_w_addr] <= bus.out_data;
            if (bus.psum_gbf_r_en) bus.psum_gbf_r_data <= mem[bus.psum_gbf_r_addr];
        end
    end

    // Log gbf traffic mid-cycle
    always @(negedge clk) begin
        if (bus.psum_gbf_w_en) begin
            wq_addr.push_back(bus.psum_gbf_w_addr);
            wq_data.push_back(bus.out_data);
            wq_cyc.push_back(cyc);
        end
        if (bus.psum_gbf_r_en) rq_addr.push_back(bus.psum_gbf_r_addr);
    end

    task automatic check(input string tag, input logic [G-1:0] got, input logic [G-1:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [G-1:0] lanes_from(input int first);
        logic [G-1:0] v = '0;
        for (int j = 0; j < G / D; j++) v[j*D +: D] = 16'(first + j);
        return v;
    endfunction

    task automatic clear_logs();
        wq_addr.delete();
        wq_data.delete();
        wq_cyc.delete();
        rq_addr.delete();
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        clr_mem = 1'b1;
        repeat (3) @(negedge clk);
        clr_mem = 1'b0;
        reset_n = 1'b1;
        @(negedge clk);
        clear_logs();
    endtask

    // Start a burst; optionally pulse pe_psum_finish (kind 1) or conv_finish (kind 2) in cycle inj.
    // Returns the cycle in which the block became idle or finished, -1 on timeout.
    task automatic run_burst(input int inj, input int kind, output int su_cyc);
        clear_logs();
        @(negedge clk) pe_psum_finish = 1'b1;
        @(negedge clk) pe_psum_finish = 1'b0;
        c0 = cyc;
        su_cyc = -1;
        for (int n = 0; n < 40; n++) begin
            if (n > 0 && (su_add_finish || done)) begin
                su_cyc = n;
                break;
            end
            if (n == inj) begin
                pe_psum_finish = kind == 1;
                conv_finish = kind == 2;
            end
            if (n == inj + 1) begin
                pe_psum_finish = 1'b0;
                conv_finish = 1'b0;
            end
            @(negedge clk);
        end
        pe_psum_finish = 1'b0;
        conv_finish = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < W / D; i++) psum_out[i*D +: D] = 16'(i);
        do_reset();
        check("rst_su", su_add_finish, 1);
        check("rst_w_en", bus.psum_gbf_w_en, 0);
        check("rst_r_en", bus.psum_gbf_r_en, 0);
        check("rst_w_addr", bus.psum_gbf_w_addr, 0);
        check("rst_out_data", bus.out_data, 0);
        check("rst_rf_addr", psum_rf_addr, 0);
        check("rst_w_num", bus.psum_gbf_w_num, 0);
        check("rst_done", done, 0);
        check("rst_overrun", overrun, 0);

        // four direct bursts over four relevant tiles
        for (int b = 0; b < 4; b++) begin
            run_burst(-5, 0, sc);
            check("dir_su_cycle", sc, BEATS + 1);
            check("dir_nwrites", wq_addr.size(), BEATS);
            check("dir_nreads", rq_addr.size(), 0);
            for (int k = 0; k < BEATS; k++)
                if (k < wq_addr.size()) check("dir_addr", wq_addr[k], b * 8 + k);
            if (wq_cyc.size() > 0) check("dir_first_w_cycle", wq_cyc[0] - c0, 1);
            check("dir_rf_addr", psum_rf_addr, (b + 1) % 4);
            check("dir_w_num", bus.psum_gbf_w_num, b == 3);
            if (b == 0 && wq_data.size() == BEATS) begin
                check("beat0_lanes", wq_data[0], lanes_from(224));
                check("beat7_lanes", wq_data[7], lanes_from(0));
            end
        end

        // accumulate: first pass direct, second pass read-modify-write with lane wrap
        do_reset();
        psum_out = '1;
        cfg_rel_num = 8'd1;
        cfg_irrel_num = 8'd2;
        cfg_acc_en = 1'b1;
        run_burst(-5, 0, sc);
        check("acc1_su_cycle", sc, BEATS + 1);
        check("acc1_nreads", rq_addr.size(), 0);
        check("acc1_nwrites", wq_addr.size(), BEATS);
        if (wq_data.size() > 0) check("acc1_data", wq_data[0], {32{16'hFFFF}});
        check("acc1_w_num", bus.psum_gbf_w_num, 0);
        run_burst(-5, 0, sc);
        check("acc2_su_cycle", sc, BEATS + 2);
        check("acc2_nreads", rq_addr.size(), BEATS);
        check("acc2_nwrites", wq_addr.size(), BEATS);
        for (int k = 0; k < BEATS; k++) begin
            if (k < rq_addr.size()) check("acc2_r_addr", rq_addr[k], k);
            if (k < wq_addr.size()) check("acc2_w_addr", wq_addr[k], k);
        end
        if (wq_cyc.size() > 0) check("acc2_first_w_cycle", wq_cyc[0] - c0, 2);
        if (wq_data.size() == BEATS) begin
            check("acc2_data0", wq_data[0], {32{16'hFFFE}});
            check("acc2_data7", wq_data[7], {32{16'hFFFE}});
        end
        check("acc2_mem3", mem[3], {32{16'hFFFE}});
        check("acc2_w_num", bus.psum_gbf_w_num, 1);

        // start pulse during a burst is ignored and flagged
        do_reset();
        for (int i = 0; i < W / D; i++) psum_out[i*D +: D] = 16'(i);
        cfg_rel_num = 8'd4;
        cfg_irrel_num = 8'd1;
        cfg_acc_en = 1'b0;
        run_burst(3, 1, sc);
        check("ovr_su_cycle", sc, BEATS + 1);
        check("ovr_nwrites", wq_addr.size(), BEATS);
        if (wq_data.size() > 0) check("ovr_beat0", wq_data[0], lanes_from(224));
        check("ovr_flag", overrun, 1);
        check("ovr_rf_addr", psum_rf_addr, 1);

        // conv_finish mid-burst: burst completes, then FINISH holds
        do_reset();
        run_burst(2, 2, sc);
        check("fin_cycle", sc, BEATS + 1);
        check("fin_nwrites", wq_addr.size(), BEATS);
        check("fin_done", done, 1);
        check("fin_su", su_add_finish, 0);
        run_burst(-5, 0, sc);
        repeat (12) @(negedge clk);
        check("fin_no_writes", wq_addr.size(), 0);
        check("fin_no_reads", rq_addr.size(), 0);
        check("fin_done_held", done, 1);

        // reset in the middle of a burst
        do_reset();
        run_burst(-5, 0, sc);
        check("rstb_pre_rf", psum_rf_addr, 1);
        clear_logs();
        @(negedge clk) pe_psum_finish = 1'b1;
        @(negedge clk) pe_psum_finish = 1'b0;
        repeat (4) @(negedge clk);
        check("rstb_w_en_before", bus.psum_gbf_w_en, 1);
        reset_n = 1'b0;
        #1;
        check("rstb_w_en_async", bus.psum_gbf_w_en, 0);
        check("rstb_su_async", su_add_finish, 1);
        check("rstb_out_data", bus.out_data, 0);
        clear_logs();
        repeat (3) @(negedge clk);
        check("rstb_no_writes", wq_addr.size(), 0);
        reset_n = 1'b1;
        @(negedge clk);
        check("rstb_rf_addr", psum_rf_addr, 0);
        check("rstb_w_num", bus.psum_gbf_w_num, 0);
        run_burst(-5, 0, sc);
        if (wq_addr.size() > 0) check("rstb_addr_restart", wq_addr[0], 0);
        check("rstb_post_rf", psum_rf_addr, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
